// File: rtl/decimal_entry_pkg.sv
// Shared types and constants for the decimal operand entry block.
package decimal_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        OFFER
    } state_t;

    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam int         SYNC_STAGES = 2;

endpackage

// File: rtl/decimal_entry_if.sv
// Operator inputs, display/status outputs and operand handshake of decimal_entry.
interface decimal_entry_if #(
    parameter int N      = 8,
    parameter int DIGITS = 3
);
    localparam int CW = $clog2(DIGITS + 1);

    logic [3:0]    digit;
    logic          key_n;
    logic          commit_n;
    logic          ready;
    logic [N-1:0]  value;
    logic          valid;
    logic          ovf;
    logic          err;
    logic [CW-1:0] count;

    // master is the entry block that sources the operand
    modport master (
        input  digit, key_n, commit_n, ready,
        output value, valid, ovf, err, count
    );

    modport slave (
        output digit, key_n, commit_n, ready,
        input  value, valid, ovf, err, count
    );
endinterface

// File: rtl/key_edge_detect.sv
// Turns an active-low level button into a one-cycle press pulse.
// DECIMAL_ENTRY_SYNC_EN adds a two-flop synchronizer ahead of the edge register.
module key_edge_detect
    import decimal_entry_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    logic level;
    logic prev_q;

`ifdef DECIMAL_ENTRY_SYNC_EN
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end

    assign level = sync_q[SYNC_STAGES-1];
`else
    assign level = btn_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= 1'b1;
        else        prev_q <= level;
    end

    // Released-to-pressed transition only, so a held button fires once.
    assign press = prev_q & ~level;
endmodule

// File: rtl/decimal_entry.sv
// Decimal digit entry: accumulates BCD presses into a saturating binary operand
// and offers it over valid/ready. Optional input sync: DECIMAL_ENTRY_SYNC_EN.
module decimal_entry
    import decimal_entry_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    decimal_entry_if.master bus
);
    localparam int             CW      = $clog2(DIGITS + 1);
    localparam logic [N+3:0]   ACC_MAX = {4'b0, {N{1'b1}}};

    state_t        state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic          valid_q;
    logic          key_p, commit_p;
    logic [N+3:0]  acc_ext, digit_ext, prod;

    key_edge_detect u_key (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (bus.key_n),
        .press (key_p)
    );

    key_edge_detect u_commit (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (bus.commit_n),
        .press (commit_p)
    );

    // x10 as (acc<<3)+(acc<<1); N+4 bits holds (2^N-1)*10+9 without wrap.
    assign acc_ext   = {4'b0, acc_q};
    assign digit_ext = {{N{1'b0}}, bus.digit};
    assign prod      = (acc_ext << 3) + (acc_ext << 1) + digit_ext;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = 1'b0;
        case (state_q)
            EMPTY, ENTRY: begin
                if (commit_p) begin
                    // A simultaneous digit press is dropped; commit in EMPTY is a no-op.
                    if (state_q == ENTRY) state_d = OFFER;
                end else if (key_p) begin
                    if (bus.digit > DIGIT_MAX || cnt_q == CW'(DIGITS)) begin
                        err_d = 1'b1;
                    end else begin
                        if (prod > ACC_MAX) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = prod[N-1:0];
                        end
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ENTRY;
                    end
                end
            end
            OFFER: begin
                if (valid_q && bus.ready) begin
                    state_d = EMPTY;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            valid_q <= (state_d == OFFER);
        end
    end

    assign bus.value = acc_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.err   = err_q;
    assign bus.count = cnt_q;
endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry (N=8, DIGITS=3); press timing holds buttons
// long enough to cover both the synchronized and unsynchronized builds.
module tb_decimal_entry;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    decimal_entry_if #(.N(8), .DIGITS(3)) bus ();

    decimal_entry #(.N(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int valid_cnt = 0;
    int off_val = 0;
    int off_ovf = 0;

    always @(negedge clk) begin
        if (bus.err === 1'b1) err_cnt++;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            off_val = int'(bus.value);
            off_ovf = int'(bus.ovf);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press_digit(input logic [3:0] d);
        bus.digit = d;
        bus.key_n = 1'b0;
        cyc(3);
        bus.key_n = 1'b1;
        cyc(3);
    endtask

    task automatic press_commit();
        bus.commit_n = 1'b0;
        cyc(3);
        bus.commit_n = 1'b1;
        cyc(3);
    endtask

    initial begin
        bus.digit    = 4'd0;
        bus.key_n    = 1'b1;
        bus.commit_n = 1'b1;
        bus.ready    = 1'b0;
        cyc(2);
        check("rst_value", bus.value, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_ovf",   bus.ovf,   0);
        check("rst_err",   bus.err,   0);
        check("rst_count", bus.count, 0);
        rst_n = 1'b1;
        cyc(2);

        // 1,2,7 committed against a permanently ready consumer
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd7);
        check("t1_entry_value", bus.value, 127);
        check("t1_entry_count", bus.count, 3);
        bus.ready = 1'b1;
        valid_cnt = 0;
        press_commit();
        check("t1_valid_cycles", valid_cnt, 1);
        check("t1_offer_value",  off_val, 127);
        check("t1_offer_ovf",    off_ovf, 0);
        check("t1_after_value",  bus.value, 0);
        check("t1_after_count",  bus.count, 0);
        bus.ready = 1'b0;

        // 300 saturates to 255
        press_digit(4'd3);
        press_digit(4'd0);
        press_digit(4'd0);
        check("t2_sat_value", bus.value, 255);
        check("t2_sat_ovf",   bus.ovf, 1);
        press_commit();
        check("t2_offer_valid", bus.valid, 1);
        check("t2_offer_ovf",   bus.ovf, 1);
        bus.ready = 1'b1;
        cyc(1);
        check("t2_hs_valid", bus.valid, 0);
        check("t2_hs_ovf",   bus.ovf, 0);
        check("t2_hs_value", bus.value, 0);
        bus.ready = 1'b0;

        // non-BCD digit is rejected
        press_digit(4'd5);
        err_cnt = 0;
        press_digit(4'd12);
        check("t3_err_cycles", err_cnt, 1);
        check("t3_count", bus.count, 1);
        check("t3_value", bus.value, 5);
        bus.ready = 1'b1;
        valid_cnt = 0;
        press_commit();
        check("t3_offer_value", off_val, 5);
        check("t3_valid_cycles", valid_cnt, 1);
        bus.ready = 1'b0;

        // fourth digit rejected once full
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd3);
        err_cnt = 0;
        press_digit(4'd4);
        check("t4_err_cycles", err_cnt, 1);
        check("t4_count", bus.count, 3);
        check("t4_value", bus.value, 123);
        bus.ready = 1'b1;
        valid_cnt = 0;
        press_commit();
        check("t4_offer_value", off_val, 123);
        check("t4_valid_cycles", valid_cnt, 1);
        bus.ready = 1'b0;

        // stalled offer ignores further digits
        press_digit(4'd4);
        press_digit(4'd2);
        press_commit();
        err_cnt = 0;
        press_digit(4'd9);
        check("t5_hold_value", bus.value, 42);
        check("t5_hold_valid", bus.valid, 1);
        check("t5_hold_count", bus.count, 2);
        check("t5_no_err", err_cnt, 0);
        bus.ready = 1'b1;
        cyc(1);
        check("t5_hs_valid", bus.valid, 0);
        check("t5_hs_value", bus.value, 0);
        bus.ready = 1'b0;

        // reset during offer discards the operand
        press_digit(4'd6);
        press_digit(4'd6);
        press_commit();
        check("t6_offer_valid", bus.valid, 1);
        check("t6_offer_value", bus.value, 66);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("t6_rst_valid", bus.valid, 0);
        check("t6_rst_value", bus.value, 0);
        check("t6_rst_count", bus.count, 0);
        valid_cnt = 0;
        err_cnt = 0;
        press_commit();
        check("t6_empty_commit_valid", valid_cnt, 0);
        check("t6_empty_commit_err", err_cnt, 0);

        // digit and commit in the same cycle: commit wins
        press_digit(4'd7);
        bus.digit    = 4'd3;
        bus.key_n    = 1'b0;
        bus.commit_n = 1'b0;
        cyc(3);
        bus.key_n    = 1'b1;
        bus.commit_n = 1'b1;
        cyc(3);
        check("t7_both_valid", bus.valid, 1);
        check("t7_both_value", bus.value, 7);
        check("t7_both_count", bus.count, 1);
        bus.ready = 1'b1;
        cyc(1);
        check("t7_hs_valid", bus.valid, 0);
        bus.ready = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
